// File: rtl/score4_pkg.sv
// Shared types and default timing for the Score 4 board button path.
// Repeat logic in debounce_channel is enabled by defining BTN_AUTOREPEAT_EN.
package score4_pkg;

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } debounce_state_t;

   localparam int CLK_HZ           = 50_000_000;
   localparam int DEBOUNCE_MS      = 10;
   localparam int REPEAT_DELAY_MS  = 500;
   localparam int REPEAT_PERIOD_MS = 200;

   localparam int CYCLES_PER_MS = CLK_HZ / 1000;

   localparam int DEF_DEBOUNCE_CYCLES = DEBOUNCE_MS * CYCLES_PER_MS;
   localparam int DEF_REPEAT_DELAY    = REPEAT_DELAY_MS * CYCLES_PER_MS;
   localparam int DEF_REPEAT_PERIOD   = REPEAT_PERIOD_MS * CYCLES_PER_MS;

endpackage

// File: rtl/debounce_channel.sv
// One button: 2-FF synchroniser, debounce FSM with saturating stability counter,
// and auto-repeat pulses when BTN_AUTOREPEAT_EN is defined. Output is active-low.
module debounce_channel
   import score4_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic btn_clean,
   output logic btn_pressed
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic            sync1_q, sync2_q;
   debounce_state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic            clean_q, clean_d;
   logic            pressed_q, pressed_d;

`ifdef BTN_AUTOREPEAT_EN
   localparam int RPT_W = $clog2(REPEAT_DELAY);
   localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_DELAY - 1);
   // Reloading to DELAY-PERIOD makes later pulses land every PERIOD cycles;
   // a period longer than the delay degrades to repeating every DELAY cycles.
   localparam logic [RPT_W-1:0] RPT_RELOAD =
      RPT_W'((REPEAT_DELAY > REPEAT_PERIOD) ? (REPEAT_DELAY - REPEAT_PERIOD) : 0);

   logic [RPT_W-1:0] rpt_q, rpt_d;
   logic             rpt_pulse;
`else
   if (REPEAT_DELAY < 0 || REPEAT_PERIOD < 0) begin : g_repeat_off
   end
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cnt_inc = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + 1'b1;

      case (state_q)
         RELEASED: begin
            if (!sync2_q) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (sync2_q) begin
               state_d = RELEASED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == CNT_LAST) state_d = PRESSED;
            end
         end
         PRESSED: begin
            if (sync2_q) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (!sync2_q) begin
               state_d = PRESSED;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == CNT_LAST) state_d = RELEASED;
            end
         end
         default: begin
            state_d = RELEASED;
            cnt_d   = '0;
         end
      endcase

      pressed_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
      clean_d   = ~pressed_d;

`ifdef BTN_AUTOREPEAT_EN
      // Timer only runs while staying in PRESSED, so a pulse due on the
      // cycle the button starts releasing never fires.
      rpt_d     = '0;
      rpt_pulse = 1'b0;
      if (state_q == PRESSED && state_d == PRESSED) begin
         if (rpt_q == RPT_LAST) begin
            rpt_pulse = 1'b1;
            rpt_d     = RPT_RELOAD;
         end else begin
            rpt_d = rpt_q + 1'b1;
         end
      end
      clean_d = ~pressed_d | rpt_pulse;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         state_q   <= RELEASED;
         cnt_q     <= '0;
         clean_q   <= 1'b1;
         pressed_q <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
         rpt_q     <= '0;
`endif
      end else begin
         sync1_q   <= btn_raw;
         sync2_q   <= sync1_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         clean_q   <= clean_d;
         pressed_q <= pressed_d;
`ifdef BTN_AUTOREPEAT_EN
         rpt_q     <= rpt_d;
`endif
      end
   end

   assign btn_clean   = clean_q;
   assign btn_pressed = pressed_q;

endmodule

// File: rtl/button_debouncer.sv
// Debounces N_BTN active-low board keys into clean active-low levels plus a
// combined "any pressed" flag. Auto-repeat is built in when BTN_AUTOREPEAT_EN is defined.
module button_debouncer
   import score4_pkg::*;
#(
   parameter int N_BTN           = 4,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_clean,
   output logic             btn_any
);

   logic [N_BTN-1:0] pressed;

   for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_channel (
         .clk         (clk),
         .rst         (rst),
         .btn_raw     (btn_raw[gi]),
         .btn_clean   (btn_clean[gi]),
         .btn_pressed (pressed[gi])
      );
   end

   // Pressed flags are flops, so this OR never sees btn_raw combinationally.
   assign btn_any = |pressed;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed scenarios plus random bouncing, checked
// every cycle against a run-length model of the debounce rules.
module tb_button_debouncer;

   localparam int N  = 4;
   localparam int D  = 8;
   localparam int RD = 32;
   localparam int RP = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] btn_raw;
   logic [N-1:0] btn_clean;
   logic         btn_any;

   always #5 clk = ~clk;

   button_debouncer #(
      .N_BTN           (N),
      .DEBOUNCE_CYCLES (D),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (btn_raw),
      .btn_clean (btn_clean),
      .btn_any   (btn_any)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [N-1:0] log_clean [0:255];
   logic         log_any   [0:255];

   // Model: raw delayed two samples; the level flips after D consecutive
   // samples disagreeing with it; age counts cycles held since (re)entry.
   bit           p1 [N];
   bit           p2 [N];
   bit           lvl [N];
   int           run [N];
   int           age [N];
   logic [N-1:0] exp_clean;
   logic         exp_any;

`ifdef BTN_AUTOREPEAT_EN
   localparam bit RPT = 1'b1;
`else
   localparam bit RPT = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         p1[i] = 1'b1; p2[i] = 1'b1; lvl[i] = 1'b0; run[i] = 0; age[i] = 0;
      end
      exp_clean = '1;
      exp_any   = 1'b0;
   endfunction

   function automatic void model_clock(input logic [N-1:0] raw);
      exp_any = 1'b0;
      for (int i = 0; i < N; i++) begin
         bit sample, pr, was_rw, pulse;
         sample = p2[i];
         p2[i]  = p1[i];
         p1[i]  = raw[i];
         pr     = (sample == 1'b0);
         was_rw = lvl[i] && (run[i] > 0);
         pulse  = 1'b0;
         if (pr != lvl[i]) run[i]++;
         else              run[i] = 0;
         if (run[i] == D) begin
            lvl[i] = ~lvl[i];
            run[i] = 0;
            age[i] = 0;
         end else if (lvl[i] && pr) begin
            if (was_rw) age[i] = 0;
            else begin
               age[i]++;
               if (RPT && (age[i] == RD || (age[i] > RD && (age[i] - RD) % RP == 0)))
                  pulse = 1'b1;
            end
         end
         exp_clean[i] = ~lvl[i] | pulse;
         exp_any      = exp_any | lvl[i];
      end
   endfunction

   task automatic step(input logic [N-1:0] raw, input logic r);
      @(negedge clk);
      check("clean", {28'd0, btn_clean}, {28'd0, exp_clean});
      check("any", {31'd0, btn_any}, {31'd0, exp_any});
      if (cyc < 256) begin
         log_clean[cyc] = btn_clean;
         log_any[cyc]   = btn_any;
      end
      btn_raw = raw;
      rst     = r;
      @(posedge clk);
      if (r) model_reset();
      else   model_clock(raw);
      cyc++;
   endtask

   function automatic int first_fall(input int ch, input int lo, input int hi);
      for (int c = lo; c <= hi; c++)
         if (log_clean[c-1][ch] && !log_clean[c][ch]) return c;
      return -1;
   endfunction

   function automatic int last_rise(input int ch, input int lo, input int hi);
      int r = -1;
      for (int c = lo; c <= hi; c++)
         if (!log_clean[c-1][ch] && log_clean[c][ch]) r = c;
      return r;
   endfunction

   function automatic int count_falls(input int ch, input int lo, input int hi);
      int n = 0;
      for (int c = lo; c <= hi; c++)
         if (log_clean[c-1][ch] && !log_clean[c][ch]) n++;
      return n;
   endfunction

   function automatic int low_cycles(input int ch, input int lo, input int hi);
      int n = 0;
      for (int c = lo; c <= hi; c++)
         if (!log_clean[c][ch]) n++;
      return n;
   endfunction

   initial begin
      int hold [N];
      logic [N-1:0] rnd_raw;
      int bad;

      btn_raw = '1;
      rst     = 1'b1;
      model_reset();

      // 1: reset values with all keys held, then release of reset
      repeat (3) step(4'h0, 1'b1);
      #1;
      check("rst_clean", {28'd0, btn_clean}, 32'hF);
      check("rst_any", {31'd0, btn_any}, 32'd0);
      cyc = 0;
      repeat (16) step(4'h0, 1'b0);
      for (int i = 0; i < N; i++) check($sformatf("rst_fall%0d", i), first_fall(i, 1, 15), 10);
      repeat (14) step(4'hF, 1'b0);

      // 2: 7-cycle low pulses separated by 1-cycle highs
      cyc = 0;
      for (int k = 0; k < 100; k++) step({3'b111, ((k % 8) == 7) ? 1'b1 : 1'b0}, 1'b0);
      bad = 0;
      for (int c = 0; c < 100; c++) if (log_any[c]) bad++;
      check("bounce_clean_low", low_cycles(0, 0, 99), 0);
      check("bounce_any_high", bad, 0);
      repeat (12) step(4'hF, 1'b0);

      // 3: clean press at 0, release at 50
      cyc = 0;
      for (int k = 0; k < 80; k++) step({2'b11, (k < 50) ? 1'b0 : 1'b1, 1'b1}, 1'b0);
      check("press_fall", first_fall(1, 1, 79), 10);
      check("press_rise", last_rise(1, 1, 79), 60);
      bad = 0;
      for (int c = 0; c < 80; c++) if (log_any[c] !== ((c >= 10) && (c < 60))) bad++;
      check("press_any_window", bad, 0);
      repeat (12) step(4'hF, 1'b0);

      // 4: long hold on channel 2
      cyc = 0;
      repeat (90) step(4'b1011, 1'b0);
      check("hold_fall", first_fall(2, 1, 89), 10);
      check("hold_edges", count_falls(2, 1, 80), RPT ? 4 : 1);
      check("hold_c42", {31'd0, log_clean[42][2]}, {31'd0, RPT});
      check("hold_c43", {31'd0, log_clean[43][2]}, 32'd0);
      check("hold_c58", {31'd0, log_clean[58][2]}, {31'd0, RPT});
      check("hold_c74", {31'd0, log_clean[74][2]}, {31'd0, RPT});
      repeat (12) step(4'hF, 1'b0);

      // 5: channel 0 at 0, channel 3 at 3
      cyc = 0;
      for (int k = 0; k < 30; k++) step({(k >= 3) ? 1'b0 : 1'b1, 2'b11, 1'b0}, 1'b0);
      check("simul_fall0", first_fall(0, 1, 29), 10);
      check("simul_fall3", first_fall(3, 1, 29), 13);
      check("simul_idle1", low_cycles(1, 0, 29), 0);
      check("simul_idle2", low_cycles(2, 0, 29), 0);
      repeat (12) step(4'hF, 1'b0);

      // 6: reset pulse while channel 1 counter is at 5
      cyc = 0;
      repeat (8) step(4'b1101, 1'b0);
      step(4'b1101, 1'b1);
      #1;
      check("midrst_clean", {28'd0, btn_clean}, 32'hF);
      check("midrst_any", {31'd0, btn_any}, 32'd0);
      cyc = 0;
      repeat (16) step(4'b1101, 1'b0);
      check("midrst_fall", first_fall(1, 1, 15), 10);
      check("midrst_idle0", low_cycles(0, 0, 15), 0);
      repeat (12) step(4'hF, 1'b0);

      // Random bouncing on all channels with occasional resets
      rnd_raw = '1;
      for (int i = 0; i < N; i++) hold[i] = $urandom_range(1, 14);
      for (int k = 0; k < 1500; k++) begin
         for (int i = 0; i < N; i++) begin
            hold[i]--;
            if (hold[i] <= 0) begin
               rnd_raw[i] = ~rnd_raw[i];
               hold[i]    = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 70)
                                                        : $urandom_range(1, 12);
            end
         end
         step(rnd_raw, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
      end
      repeat (20) step(4'hF, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
